// File: rtl/morse_keyer_pkg.sv
// morse_keyer_pkg: shared FSM states, event codes and default keyer timing
package morse_keyer_pkg;
    typedef enum logic [1:0] {IDLE, PRESS, HOLD, GAP} state_t;
    typedef enum logic [2:0] {EV_NONE, EV_DOT, EV_DASH, EV_ENTER, EV_CANCEL} ev_t;
    localparam int CNT_W_DEF        = 12;
    localparam int MIN_PRESS_MS_DEF = 20;
    localparam int DASH_MS_DEF      = 300;
    localparam int GAP_MS_DEF       = 700;
    localparam int LONG_MS_DEF      = 2000;
    localparam int MAX_SYM_DEF      = 5;
endpackage

// File: rtl/morse_keyer_ms_timer.sv
// morse_keyer_ms_timer: saturating millisecond counter with keyer threshold compares
module morse_keyer_ms_timer #(
    parameter int CNT_W   = 12,
    parameter int MIN_MS  = 20,
    parameter int DASH_MS = 300,
    parameter int GAP_MS  = 700,
    parameter int LONG_MS = 2000
) (
    input  logic clk,
    input  logic rst,
    input  logic tick,
    input  logic clr,
    output logic ge_min,
    output logic ge_dash,
    output logic eq_gap,
    output logic eq_long
);
    logic [CNT_W-1:0] cnt;

    // clear wins over a coincident tick; count holds at all-ones
    always_ff @(posedge clk) begin
        if (rst || clr) cnt <= '0;
        else if (tick && cnt != '1) cnt <= cnt + 1'b1;
    end

    assign ge_min  = cnt >= CNT_W'(MIN_MS);
    assign ge_dash = cnt >= CNT_W'(DASH_MS);
    assign eq_gap  = tick && cnt == CNT_W'(GAP_MS - 1);
    assign eq_long = tick && cnt == CNT_W'(LONG_MS - 1);
endmodule

// File: rtl/morse_keyer.sv
// morse_keyer: single-key Morse timing front end producing dot/dash/enter/cancel pulses
module morse_keyer
    import morse_keyer_pkg::*;
#(
    parameter int CNT_W        = CNT_W_DEF,
    parameter int MIN_PRESS_MS = MIN_PRESS_MS_DEF,
    parameter int DASH_MS      = DASH_MS_DEF,
    parameter int GAP_MS       = GAP_MS_DEF,
    parameter int LONG_MS      = LONG_MS_DEF,
    parameter int MAX_SYM      = MAX_SYM_DEF
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tick_1ms,
    input  logic       key_in,
    output logic       dot_pulse,
    output logic       dash_pulse,
    output logic       enter_pulse,
    output logic       cancel_pulse,
    output logic       key_active,
    output logic [2:0] sym_count,
    output logic       overflow
);
    state_t state;
    ev_t    ev;
    logic   key_q, rise, fall, ge_min, ge_dash, eq_gap, eq_long;

    assign rise       = key_in & ~key_q;
    assign fall       = ~key_in & key_q;
    assign key_active = key_q;

    morse_keyer_ms_timer #(
        .CNT_W(CNT_W), .MIN_MS(MIN_PRESS_MS), .DASH_MS(DASH_MS), .GAP_MS(GAP_MS), .LONG_MS(LONG_MS)
    ) u_timer (
        .clk(clk), .rst(rst), .tick(tick_1ms), .clr(rise | fall),
        .ge_min(ge_min), .ge_dash(ge_dash), .eq_gap(eq_gap), .eq_long(eq_long)
    );

    // keyer FSM: classifies presses and silences into a single event per cycle
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            key_q     <= 1'b0;
            ev        <= EV_NONE;
            sym_count <= '0;
            overflow  <= 1'b0;
        end else begin
            key_q <= key_in;
            ev    <= EV_NONE;
            case (state)
                IDLE: if (rise) state <= PRESS;
                PRESS: begin
                    if (fall) begin
                        if (!ge_min) state <= (sym_count == '0) ? IDLE : GAP;
                        else begin
                            state <= GAP;
                            if (sym_count == 3'(MAX_SYM)) overflow <= 1'b1;
                            else begin
                                sym_count <= sym_count + 3'd1;
                                ev        <= ge_dash ? EV_DASH : EV_DOT;
                            end
                        end
                    end else if (eq_long) begin
                        ev        <= EV_CANCEL;
                        sym_count <= '0;
                        overflow  <= 1'b0;
                        state     <= HOLD;
                    end
                end
                HOLD: if (fall) state <= IDLE;
                GAP: begin
                    if (rise) state <= PRESS;
                    else if (eq_gap) begin
                        ev        <= EV_ENTER;
                        sym_count <= '0;
                        overflow  <= 1'b0;
                        state     <= IDLE;
                    end
                end
            endcase
        end
    end

    // output stage: one registered, mutually exclusive pulse per event
    always_ff @(posedge clk) begin
        if (rst) begin
            dot_pulse    <= 1'b0;
            dash_pulse   <= 1'b0;
            enter_pulse  <= 1'b0;
            cancel_pulse <= 1'b0;
        end else begin
            dot_pulse    <= ev == EV_DOT;
            dash_pulse   <= ev == EV_DASH;
            enter_pulse  <= ev == EV_ENTER;
            cancel_pulse <= ev == EV_CANCEL;
        end
    end
endmodule
